// File: rtl/rca4_shared_seq_adder.sv
// Time-multiplexed wide unsigned adder: two requesters share one 4-bit
// ripple-carry slice. A round-robin arbiter accepts one operand pair. The
// sequencer then adds one nibble per cycle, LSB first, through a registered
// carry, and returns a (W+1)-bit sum on a valid/ready response port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A requester holds valid and its operands stable until it
// sees ready. The consumer may hold rsp_ready low for any number of cycles,
// and rsp_sum/rsp_id stay stable meanwhile.
module rca4_shared_seq_adder #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [4*N_NIB-1:0]   req0_a,
  input  logic [4*N_NIB-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [4*N_NIB-1:0]   req1_a,
  input  logic [4*N_NIB-1:0]   req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*N_NIB:0]     rsp_sum,
  output logic                 rsp_id,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  localparam int W  = 4 * N_NIB;
  localparam int KW = $clog2(N_NIB) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W:0]      sum_q, sum_d;
  logic            c_q, c_d;
  logic [KW-1:0]   k_q, k_d;
  logic            id_q, id_d;
  logic            last_q, last_d;

  logic            grant;
  logic            accept;
  logic [W-1:0]    a_sh, b_sh;
  logic [3:0]      nib_a, nib_b, nib_s;
  logic [4:0]      cy;
  logic            last_nib;

  // Round-robin grant: a lone requester always wins; under contention the
  // requester that did not win last time gets the slot.
  always_comb begin
    grant      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    req0_ready = (state_q == ST_IDLE) & req0_valid & ~grant & rst_n;
    req1_ready = (state_q == ST_IDLE) & req1_valid &  grant & rst_n;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  // Shared slice: four chained full adders on nibble k with carry-in c_q.
  always_comb begin
    a_sh     = a_q >> {k_q, 2'b00};
    b_sh     = b_q >> {k_q, 2'b00};
    nib_a    = a_sh[3:0];
    nib_b    = b_sh[3:0];
    nib_s    = 4'd0;
    cy       = 5'd0;
    cy[0]    = c_q;
    for (int j = 0; j < 4; j++) begin
      nib_s[j]  = nib_a[j] ^ nib_b[j] ^ cy[j];
      cy[j + 1] = (nib_a[j] & nib_b[j]) | (cy[j] & (nib_a[j] ^ nib_b[j]));
    end
    last_nib = (k_q == KW'(N_NIB - 1));
  end

  // Sequencer next state: latch on accept, one nibble per ADD cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    k_d     = k_q;
    id_d    = id_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          id_d    = grant;
          last_d  = grant;
          c_d     = 1'b0;
          k_d     = '0;
          sum_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < N_NIB; i++) begin
          if (k_q == KW'(i)) sum_d[4*i +: 4] = nib_s;
        end
        c_d = cy[4];
        k_d = k_q + KW'(1);
        if (last_nib) begin
          sum_d[W] = cy[4];
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      k_q     <= k_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Registered response and status outputs.
  always_comb begin
    rsp_valid   = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    rsp_sum     = sum_q;
    rsp_id      = id_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_rca4_shared_seq_adder.sv
// Directed bench for rca4_shared_seq_adder: an N_NIB=4 and an N_NIB=1 instance
// share one clock and reset and are driven from a single linear sequence.
module tb_rca4_shared_seq_adder;

  localparam int N4 = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // N_NIB=4 instance signals
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [16:0] rsp_sum;
  logic [1:0]  dbg_state;

  // N_NIB=1 instance signals
  logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [3:0]  s_req0_a, s_req0_b, s_req1_a, s_req1_b;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_busy;
  logic [4:0]  s_rsp_sum;
  logic [1:0]  s_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  rca4_shared_seq_adder #(.N_NIB(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  rca4_shared_seq_adder #(.N_NIB(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_sum(s_rsp_sum), .rsp_id(s_rsp_id),
    .busy(s_busy), .dbg_state_o(s_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair on requester id, wait (bounded) for ready, complete the handshake.
  task automatic send4(input bit id, input logic [15:0] a, input logic [15:0] b);
    bit got;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (id ? req1_ready : req0_ready) got = 1'b1;
      else step();
    end
    chk("accept_seen", 32'(got), 32'd1);
    chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
    step();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Called just after the accept edge E0: response must appear after E(N4).
  task automatic expect_rsp(input logic [16:0] exp_sum, input bit exp_id);
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 0; i < N4; i++) begin
      chk("rsp_not_early", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("rsp_valid_on_time", 32'(rsp_valid), 32'd1);
    chk("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
    chk("rsp_id", 32'(rsp_id), 32'(exp_id));
    chk("busy_in_done", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("busy_after_hs", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_ids[4];
    int n_acc, n_rsp, last_cyc;

    // ---- reset ----
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    s_req0_valid = 1'b0; s_req1_valid = 1'b0; s_rsp_ready = 1'b0;
    s_req0_a = '0; s_req0_b = '0; s_req1_a = '0; s_req1_b = '0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    step(); step();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // ---- N_NIB=1: contention, alternation, single-nibble carry ----
    s_req0_valid = 1'b1; s_req0_a = 4'h3; s_req0_b = 4'h4;
    s_req1_valid = 1'b1; s_req1_a = 4'h8; s_req1_b = 4'h9;
    #1;
    chk("n1_first_grant0", 32'(s_req0_ready), 32'd1);
    chk("n1_first_grant1", 32'(s_req1_ready), 32'd0);
    step();
    s_req0_valid = 1'b0;
    chk("n1_busy", 32'(s_busy), 32'd1);
    chk("n1_rsp_not_early", 32'(s_rsp_valid), 32'd0);
    step();
    chk("n1_rsp_valid", 32'(s_rsp_valid), 32'd1);
    chk("n1_rsp_sum_a", 32'(s_rsp_sum), 32'h07);
    chk("n1_rsp_id_a", 32'(s_rsp_id), 32'd0);
    s_rsp_ready = 1'b1;
    step();
    s_rsp_ready = 1'b0;
    s_req0_valid = 1'b1;
    #1;
    chk("n1_second_grant1", 32'(s_req1_ready), 32'd1);
    chk("n1_second_grant0", 32'(s_req0_ready), 32'd0);
    step();
    s_req0_valid = 1'b0; s_req1_valid = 1'b0;
    step();
    chk("n1_rsp_sum_b", 32'(s_rsp_sum), 32'h11);
    chk("n1_rsp_id_b", 32'(s_rsp_id), 32'd1);
    s_rsp_ready = 1'b1;
    step();
    s_rsp_ready = 1'b0;
    s_req0_valid = 1'b1; s_req0_a = 4'hF; s_req0_b = 4'h1;
    #1;
    chk("n1_single_grant", 32'(s_req0_ready), 32'd1);
    step();
    s_req0_valid = 1'b0;
    chk("n1_carry_not_early", 32'(s_rsp_valid), 32'd0);
    step();
    chk("n1_carry_valid", 32'(s_rsp_valid), 32'd1);
    chk("n1_carry_sum", 32'(s_rsp_sum), 32'h10);
    s_rsp_ready = 1'b1;
    step();
    s_rsp_ready = 1'b0;
    chk("n1_idle_after", 32'(s_busy), 32'd0);

    // ---- N_NIB=4 basic add ----
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321;
    #1;
    chk("basic_ready0", 32'(req0_ready), 32'd1);
    chk("basic_ready1", 32'(req1_ready), 32'd0);
    chk("basic_busy_idle", 32'(busy), 32'd0);
    step();
    req0_valid = 1'b0;
    expect_rsp(17'h05555, 1'b0);

    // ---- full-width carry ripple ----
    send4(1'b1, 16'hFFFF, 16'h0001);
    expect_rsp(17'h10000, 1'b1);
    send4(1'b0, 16'hFFFF, 16'hFFFF);
    expect_rsp(17'h1FFFE, 1'b0);
    send4(1'b1, 16'h0000, 16'h0000);
    expect_rsp(17'h00000, 1'b1);

    // ---- contention after reset with rsp_ready held high ----
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1; req1_a = 16'h00F0; req1_b = 16'h0010;
    rsp_ready = 1'b1;
    #1;
    exp_ids = '{0, 1, 0, 1};
    n_acc = 0; n_rsp = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 60 && n_rsp < 4; cyc++) begin
      chk("rr_one_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (rsp_valid) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'(exp_ids[n_rsp]));
        chk("rr_rsp_sum", 32'(rsp_sum), (exp_ids[n_rsp] == 0) ? 32'h00003 : 32'h00100);
        n_rsp++;
      end
      if ((req0_ready | req1_ready) && n_acc < 4) begin
        chk("rr_grant", 32'(req1_ready), 32'(exp_ids[n_acc]));
        if (n_acc > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd6);
        last_cyc = cyc;
        n_acc++;
      end
      step();
      if (n_acc == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("rr_accepts", 32'(n_acc), 32'd4);
    chk("rr_responses", 32'(n_rsp), 32'd4);
    rsp_ready = 1'b0;

    // ---- backpressure in DONE ----
    send4(1'b0, 16'h00AA, 16'h0055);
    for (int i = 0; i < N4; i++) step();
    req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0202;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_sum_held", 32'(rsp_sum), 32'h000FF);
      chk("bp_id_held", 32'(rsp_id), 32'd0);
      chk("bp_ready0_low", 32'(req0_ready), 32'd0);
      chk("bp_ready1_low", 32'(req1_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready0_still_low", 32'(req0_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    chk("bp_ready0_after_hs", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    expect_rsp(17'h00303, 1'b0);

    // ---- reset in the second ADD cycle ----
    send4(1'b0, 16'h1111, 16'h2222);
    step();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 16'h8000; req0_b = 16'h8000;
    req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
    chk("mid_rst_ready1", 32'(req1_ready), 32'd0);
    chk("mid_rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", 32'(req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    expect_rsp(17'h10000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rca4_shared_seq_adder.md
Name: rca4_shared_seq_adder

Overview:
- Time-multiplexed wide unsigned adder. It shares a single 4-bit ripple-carry slice between two requesters.
- A round-robin arbiter accepts one operand pair at a time. The sequencer then feeds the slice one nibble per cycle, LSB first, through a registered carry, and returns a (W+1)-bit sum with a valid/ready response.
- Sits between client logic and the arithmetic datapath. Used where area matters more than throughput.

Parameters:
- N_NIB, 4, number of 4-bit nibbles per operand. Operand width W = 4*N_NIB. Legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_ready  output  1  requester 0 pair accepted this cycle when high with req0_valid
- req0_a  input  W  requester 0 operand A
- req0_b  input  W  requester 0 operand B
- req1_valid  input  1  requester 1 has an operand pair
- req1_ready  output  1  requester 1 accept
- req1_a  input  W  requester 1 operand A
- req1_b  input  W  requester 1 operand B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_sum  output  W+1  A+B; bit W is the carry out
- rsp_id  output  1  index of the requester that owns rsp_sum
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Datapath slice:
  - Four full-adder cells chained, with carry-in from carry register c_q.
  - Nibble k computes a_q[4k+3:4k] + b_q[4k+3:4k] + c_q.
  - The 4-bit sum is written to sum_q[4k+3:4k]; the slice carry-out is written to c_q.
- Registers: a_q, b_q (W), sum_q (W+1), c_q, k (nibble index, ceil(log2 N_NIB)+1 bits), id_q, last_q (round-robin pointer), state.
- States:
  - IDLE:
    - Grant = the valid requester. If both are valid, grant the one not equal to last_q.
    - reqX_ready is combinational and equals (state==IDLE) & grant==X & rst_n. At most one ready is high at a time.
    - On valid&ready: latch a, b and id; set last_q=id, c_q=0, k=0, sum_q=0; go to ADD.
    - With no valid, stay in IDLE.
  - ADD:
    - Each cycle, process nibble k and increment k.
    - When k==N_NIB-1: also write sum_q[W]=slice carry-out and go to DONE.
    - Occupies exactly N_NIB cycles.
  - DONE:
    - rsp_valid=1. rsp_sum=sum_q and rsp_id=id_q are held stable.
    - On rsp_ready go to IDLE. Both reqX_ready stay low.
    - The earliest new accept is the cycle after the response handshake.
- Latency: request handshake at edge E0 makes rsp_valid high after edge E(N_NIB). Peak throughput is one result per N_NIB+2 cycles.
- rsp_sum and rsp_id are registered outputs. They hold their last value in IDLE and ADD; only DONE values are meaningful.
- Width rule: rsp_sum is exact unsigned A+B. No overflow is possible.
- Arbitration:
  - last_q resets to 1, so req0 wins the first contention.
  - The pointer updates only on an accepted request.
  - A single valid requester is granted regardless of last_q.
- Requester rule: valid and operands stay stable until ready. The block latches only on handshake, so a changing valid never corrupts an operation in flight.
- Reset (rst_n low, any state, including mid-ADD or DONE):
  - Immediately: state=IDLE, rsp_valid=0, busy=0, req0_ready=0, req1_ready=0, rsp_sum=0, rsp_id=0, last_q=1, c_q=0, k=0.
  - The in-flight operation is discarded with no response.
  - The first accept is possible on the first edge with rst_n high.

Test Plan:
- N_NIB=4. req0 sends A=0x1234, B=0x4321 -> req0_ready high in IDLE; rsp_valid 4 cycles after accept; rsp_sum=0x05555, rsp_id=0; busy high from accept until the rsp handshake.
- Full-width carry ripple:
  - req1 sends 0xFFFF+0x0001 -> rsp_sum=0x10000, rsp_id=1.
  - 0xFFFF+0xFFFF -> rsp_sum=0x1FFFE.
  - 0x0000+0x0000 -> rsp_sum=0x00000.
- Both valid continuously after reset with rsp_ready=1 -> grants alternate 0,1,0,1. req0 gets 0x0001+0x0002=0x00003 and req1 gets 0x00F0+0x0010=0x00100. Accepts are spaced 6 cycles apart. Only one ready is high at a time.
- Backpressure: rsp_ready held low 3 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stay stable; req0_ready and req1_ready stay low although req0_valid is high. Accept occurs the cycle after rsp_ready rises.
- Reset asserted in the 2nd ADD cycle -> all outputs zero asynchronously and no response appears. After release, 0x8000+0x8000 -> rsp_sum=0x10000 with correct latency, and req0 wins if both requesters are valid.
- N_NIB=1 build: 0xF+0x1 -> rsp_sum=0x10 one cycle after accept. Arbitration matches the N_NIB=4 behaviour.
